multiplier32: RTL

Sequential signed 32×32→64 multiplier, the inverse-direction companion to the team's 32-bit signed divider. It uses the same valid/ready handshake and reset style as the divider, so the two can share a datapath controller. Its planned use is arithmetic-unit multiply and on-chip round-trip checking of divider results (Q·DIVISOR + R = DIVIDEND). It computes one product with a radix-2 shift-add loop over magnitudes, then applies a final sign correction.

---
 rtl/multiplier32.sv | 98 +++++++++
 1 files changed

// File: rtl/multiplier32.sv
// multiplier32: sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier.
// Radix-2 shift-add over operand magnitudes, one bit per clock, followed
// by a single sign-correction cycle. valid/ready handshake: a start is
// accepted whenever the block is idle or holding a finished result.
module multiplier32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 async_rst,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     MULTIPLICAND,
  input  logic [WIDTH-1:0]     MULTIPLIER,
  output logic [2*WIDTH-1:0]   P,
  output logic                 ready
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand;     // multiplicand magnitude, shifted left each iteration
  logic [WIDTH-1:0]     mplier;    // multiplier magnitude, shifted right each iteration
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic                 start;
  logic [WIDTH-1:0]     mag_a, mag_b;

  // Operand magnitudes; the most negative value negates to itself and is
  // then read as an unsigned 2^(WIDTH-1), which is exactly the magnitude.
  always_comb begin
    mag_a = MULTIPLICAND[WIDTH-1] ? (~MULTIPLICAND + 1'b1) : MULTIPLICAND;
    mag_b = MULTIPLIER[WIDTH-1]   ? (~MULTIPLIER + 1'b1)   : MULTIPLIER;
  end

  // State register.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic and start decode.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (valid) begin
          start     = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST_ITER) state_nxt = SIGN;
      end
      SIGN: begin
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iterations, sign-corrected result.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      P      <= '0;
      ready  <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      neg    <= MULTIPLICAND[WIDTH-1] ^ MULTIPLIER[WIDTH-1];
      acc    <= '0;
      cnt    <= '0;
      ready  <= 1'b0;
    end else if (state == CALC) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end else if (state == SIGN) begin
      P      <= neg ? (~acc + 1'b1) : acc;
      ready  <= 1'b1;
    end
  end

endmodule
